// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking slot display path.
//   - 5-bit glyph codes understood by the seven-segment decoders
//   - 7-bit active-low segment patterns, bit 6 = segment a ... bit 0 = g
//   - scan state encoding used by the multiplexed display driver
// ---------------------------------------------------------------------------
package parking_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    // Glyph codes; 0..9 are the decimal digits themselves.
    localparam logic [CODE_W-1:0] GLYPH_L     = 5'd10;
    localparam logic [CODE_W-1:0] GLYPH_U     = 5'd11;
    localparam logic [CODE_W-1:0] GLYPH_F     = 5'd12;
    localparam logic [CODE_W-1:0] GLYPH_O     = 5'd13;
    localparam logic [CODE_W-1:0] GLYPH_P     = 5'd14;
    localparam logic [CODE_W-1:0] GLYPH_E     = 5'd15;
    localparam logic [CODE_W-1:0] GLYPH_N     = 5'd16;
    localparam logic [CODE_W-1:0] GLYPH_DASH  = 5'd17;
    localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'd18;

    // Active-low segment patterns {a,b,c,d,e,f,g}.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_L     = 7'b1110001;
    localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_O     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_P     = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_N     = 7'b1101010;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Scan slot phase: one dark GAP cycle, then DRIVE for the rest of the slot.
    typedef enum logic {
        SCAN_GAP   = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

endpackage : parking_pkg

// File: rtl/seg_glyph_rom.sv
// ---------------------------------------------------------------------------
// seg_glyph_rom
// Combinational glyph decoder: 5-bit glyph code to active-low segment pattern.
// Shared by every seven-segment display in the parking system.
// Ports:
//   code_i  in  5 : glyph code (0..9 digits, 10..17 letters/dash, 18..31 blank)
//   seg_o   out 7 : active-low segments, seg_o[6]=a ... seg_o[0]=g
// ---------------------------------------------------------------------------
module seg_glyph_rom
    import parking_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [SEG_W-1:0]  seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            5'd0:       seg_o = SEG_0;
            5'd1:       seg_o = SEG_1;
            5'd2:       seg_o = SEG_2;
            5'd3:       seg_o = SEG_3;
            5'd4:       seg_o = SEG_4;
            5'd5:       seg_o = SEG_5;
            5'd6:       seg_o = SEG_6;
            5'd7:       seg_o = SEG_7;
            5'd8:       seg_o = SEG_8;
            5'd9:       seg_o = SEG_9;
            GLYPH_L:    seg_o = SEG_L;
            GLYPH_U:    seg_o = SEG_U;
            GLYPH_F:    seg_o = SEG_F;
            GLYPH_O:    seg_o = SEG_O;
            GLYPH_P:    seg_o = SEG_P;
            GLYPH_E:    seg_o = SEG_E;
            GLYPH_N:    seg_o = SEG_N;
            GLYPH_DASH: seg_o = SEG_DASH;
            default:    seg_o = SEG_BLANK;  // 18..31 are all dark
        endcase
    end

endmodule : seg_glyph_rom

// File: rtl/parking_display_scan.sv
// ---------------------------------------------------------------------------
// parking_display_scan
// Multiplexed N-digit seven-segment driver. Latches a multi-digit message into
// a shadow register and scans it one digit at a time onto a shared segment
// bus, with a one-cycle dark gap at the start of every digit slot to prevent
// ghosting, an optional blink mode and a once-per-frame tick.
// Ports:
//   clk         in  1       : system clock, rising edge
//   rst_n       in  1       : asynchronous active-low reset
//   code_bus    in  5*N     : glyph codes, digit i at [5i+4:5i], digit 0 rightmost
//   load        in  1       : copy code_bus into the shadow register
//   blink_en    in  1       : enable blinking at the BLINK_FRAMES rate
//   blank       in  1       : force display dark (scan keeps running)
//   seg         out 7       : active-low segments, seg[6]=a ... seg[0]=g
//   an          out N       : active-low anode enables, one-hot-low in DRIVE
//   frame_tick  out 1       : pulse on the cycle the scan returns to digit 0
// ---------------------------------------------------------------------------
module parking_display_scan
    import parking_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CODE_W*NUM_DIGITS-1:0] code_bus,
    input  logic                         load,
    input  logic                         blink_en,
    input  logic                         blank,
    output logic [SEG_W-1:0]             seg,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_tick
);

    localparam int DIV_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int IDX_W = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0]                  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]                  dig_idx_q, dig_idx_d;
    logic [FRM_W-1:0]                  frame_cnt_q, frame_cnt_d;
    logic                              blink_phase_q, blink_phase_d;
    scan_state_e                       state_q, state_d;

    logic [SEG_W-1:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]             an_q, an_d;
    logic                              frame_tick_q, frame_tick_d;

    logic                              div_last, idx_last, frame_last, wrap;
    logic                              dark_d, show_d;
    logic [CODE_W-1:0]                 glyph_code;
    logic [SEG_W-1:0]                  glyph_seg;

    // Counter next-state
    always_comb begin
        div_last   = (div_cnt_q   == DIV_W'(REFRESH_DIV - 1));
        idx_last   = (dig_idx_q   == IDX_W'(NUM_DIGITS - 1));
        frame_last = (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1));
        wrap       = div_last && idx_last;

        div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);

        dig_idx_d = dig_idx_q;
        if (div_last) begin
            dig_idx_d = idx_last ? '0 : dig_idx_q + IDX_W'(1);
        end

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wrap) begin
            frame_cnt_d = frame_last ? '0 : frame_cnt_q + FRM_W'(1);
            if (frame_last) begin
                blink_phase_d = ~blink_phase_q;
            end
        end

        shadow_d = load ? code_bus : shadow_q;
    end

    // GAP always lasts one cycle; DRIVE ends when the slot divider wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN_GAP:   state_d = SCAN_DRIVE;
            SCAN_DRIVE: state_d = div_last ? SCAN_GAP : SCAN_DRIVE;
            default:    state_d = SCAN_GAP;
        endcase
    end

    // The glyph for the digit about to be shown is taken from the shadow as it
    // stands before this edge, so a load lands on seg one edge after capture.
    always_comb begin
        glyph_code = GLYPH_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx_d == IDX_W'(i)) begin
                glyph_code = shadow_q[i];
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .code_i (glyph_code),
        .seg_o  (glyph_seg)
    );

    // Output next-state: outputs always describe the slot position being
    // entered, so they line up with div_cnt/dig_idx during the same cycle.
    always_comb begin
        dark_d       = blank | (blink_en & ~blink_phase_d);
        show_d       = (state_d == SCAN_DRIVE) && !dark_d;
        seg_d        = show_d ? glyph_seg : SEG_BLANK;
        frame_tick_d = wrap;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !(show_d && (dig_idx_d == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= {NUM_DIGITS{GLYPH_BLANK}};
            div_cnt_q     <= '0;
            dig_idx_q     <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            state_q       <= SCAN_GAP;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            div_cnt_q     <= div_cnt_d;
            dig_idx_q     <= dig_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule : parking_display_scan
